// File: rtl/vga_fill_engine.sv
// Rectangle fill engine on the CPU-to-framebuffer write path.
// Ordinary CPU writes pass through and take priority over engine writes.
module vga_fill_engine #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] cpu_addr,
  input  logic [31:0] cpu_datain,
  input  logic        cpu_we,
  output logic [23:0] fb_addr,
  output logic [31:0] fb_datain,
  output logic        fb_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SWAP,
    S_DONE
  } state_t;

  localparam logic [23:0] A_RECT0 = 24'hfffff0;
  localparam logic [23:0] A_RECT1 = 24'hfffff4;
  localparam logic [23:0] A_CMD   = 24'hfffff8;
  localparam logic [23:0] A_SWAP  = 24'hfffffc;
  localparam logic [9:0]  XMAX    = 10'(WIDTH - 1);
  localparam logic [9:0]  YMAX    = 10'(HEIGHT - 1);

  state_t      state_q;
  logic [9:0]  rx0_q, ry0_q, rx1_q, ry1_q;
  logic [9:0]  wx0_q, wx1_q, wy1_q;
  logic [9:0]  x_q, y_q;
  logic        col_q, swap_q;
  logic        busy_q, done_q;

  logic        wr_rect0, wr_rect1, wr_cmd;
  logic        is_reg, stall;
  logic [9:0]  x1_d, y1_d;
  logic        empty_d;
  logic        eng_we;
  logic [23:0] eng_addr;
  logic [31:0] eng_data;

  // Decode CPU writes: engine registers vs. framebuffer pass-through
  always_comb begin
    wr_rect0 = cpu_we && (cpu_addr == A_RECT0);
    wr_rect1 = cpu_we && (cpu_addr == A_RECT1);
    wr_cmd   = cpu_we && (cpu_addr == A_CMD);
    is_reg   = (cpu_addr == A_RECT0) || (cpu_addr == A_RECT1) ||
               (cpu_addr == A_CMD);
    stall    = cpu_we && !is_reg;
  end

  // Clamp far corner to the screen and detect an empty rectangle
  always_comb begin
    x1_d    = (rx1_q > XMAX) ? XMAX : rx1_q;
    y1_d    = (ry1_q > YMAX) ? YMAX : ry1_q;
    empty_d = (rx0_q > x1_d) || (ry0_q > y1_d) ||
              (rx0_q > XMAX) || (ry0_q > YMAX);
  end

  // Engine write port, suppressed while a CPU write owns the bus
  always_comb begin
    eng_we   = !stall && ((state_q == S_FILL) || (state_q == S_SWAP));
    eng_addr = (state_q == S_SWAP) ? A_SWAP : {4'h0, y_q, x_q};
    eng_data = (state_q == S_SWAP) ? 32'h0 : {31'b0, col_q};
  end

  // Framebuffer bus mux: CPU pass-through has priority
  always_comb begin
    if (stall) begin
      fb_we     = 1'b1;
      fb_addr   = cpu_addr;
      fb_datain = cpu_datain;
    end else begin
      fb_we     = eng_we;
      fb_addr   = eng_addr;
      fb_datain = eng_data;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Register file, operation latch and fill sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rx0_q   <= '0;
      ry0_q   <= '0;
      rx1_q   <= '0;
      ry1_q   <= '0;
      wx0_q   <= '0;
      wx1_q   <= '0;
      wy1_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= 1'b0;
      swap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_rect0) begin
        rx0_q <= cpu_datain[9:0];
        ry0_q <= cpu_datain[25:16];
      end
      if (wr_rect1) begin
        rx1_q <= cpu_datain[9:0];
        ry1_q <= cpu_datain[25:16];
      end
      unique case (state_q)
        S_IDLE: begin
          if (wr_cmd) begin
            col_q  <= cpu_datain[0];
            swap_q <= cpu_datain[1];
            wx0_q  <= rx0_q;
            wx1_q  <= x1_d;
            wy1_q  <= y1_d;
            x_q    <= rx0_q;
            y_q    <= ry0_q;
            busy_q <= 1'b1;
            if (!empty_d) begin
              state_q <= S_FILL;
            end else if (cpu_datain[1]) begin
              state_q <= S_SWAP;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (!stall) begin
            if (x_q == wx1_q) begin
              if (y_q == wy1_q) begin
                if (swap_q) begin
                  state_q <= S_SWAP;
                end else begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              end else begin
                x_q <= wx0_q;
                y_q <= y_q + 10'd1;
              end
            end else begin
              x_q <= x_q + 10'd1;
            end
          end
        end
        S_SWAP: begin
          if (!stall) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fill_engine.sv
// Directed testbench for vga_fill_engine.
// Hand-computed pixel sequences checked with immediate assertions.
module tb_vga_fill_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cpu_addr;
  logic [31:0] cpu_datain;
  logic        cpu_we;
  logic [23:0] fb_addr;
  logic [31:0] fb_datain;
  logic        fb_we;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] R0  = 24'hfffff0;
  localparam logic [23:0] R1  = 24'hfffff4;
  localparam logic [23:0] CMD = 24'hfffff8;
  localparam logic [23:0] SWP = 24'hfffffc;

  vga_fill_engine #(.WIDTH(640), .HEIGHT(480)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_datain(cpu_datain),
    .cpu_we    (cpu_we),
    .fb_addr   (fb_addr),
    .fb_datain (fb_datain),
    .fb_we     (fb_we),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xy(input int x, input int y);
    logic [9:0] xs, ys;
    xs = x[9:0];
    ys = y[9:0];
    return {6'b0, ys, 6'b0, xs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs change just after the edge, outputs settle
  task automatic cyc(input logic we, input logic [23:0] a,
                     input logic [31:0] d);
    @(posedge clk);
    #1;
    cpu_we     = we;
    cpu_addr   = a;
    cpu_datain = d;
    #1;
  endtask

  task automatic exp_pix(input string tag, input int x, input int y,
                         input logic c);
    logic [9:0] xs, ys;
    xs = x[9:0];
    ys = y[9:0];
    chk({tag, ".we"}, 32'(fb_we), 32'd1);
    chk({tag, ".addr"}, 32'(fb_addr), {8'h0, 4'h0, ys, xs});
    chk({tag, ".data"}, fb_datain, 32'(c));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask

  task automatic exp_swap(input string tag);
    chk({tag, ".we"}, 32'(fb_we), 32'd1);
    chk({tag, ".addr"}, 32'(fb_addr), 32'(SWP));
    chk({tag, ".data"}, fb_datain, 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic exp_cpu(input string tag, input logic [23:0] a,
                         input logic [31:0] d);
    chk({tag, ".we"}, 32'(fb_we), 32'd1);
    chk({tag, ".addr"}, 32'(fb_addr), 32'(a));
    chk({tag, ".data"}, fb_datain, d);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic exp_st(input string tag, input logic b, input logic dn);
    chk({tag, ".we"}, 32'(fb_we), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  initial begin
    reset      = 1'b1;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_datain = '0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    exp_st("reset", 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0);
    exp_st("post_reset", 0, 0);

    // Basic fill, colour 1, no swap
    cyc(1, R0, xy(2, 3));
    exp_st("rect0_wr", 0, 0);
    cyc(1, R1, xy(4, 4));
    exp_st("rect1_wr", 0, 0);
    cyc(1, CMD, 32'h1);
    exp_st("cmd1", 0, 0);
    cyc(0, 0, 0); exp_pix("t1p0", 2, 3, 1);
    cyc(0, 0, 0); exp_pix("t1p1", 3, 3, 1);
    cyc(0, 0, 0); exp_pix("t1p2", 4, 3, 1);
    cyc(0, 0, 0); exp_pix("t1p3", 2, 4, 1);
    cyc(0, 0, 0); exp_pix("t1p4", 3, 4, 1);
    cyc(0, 0, 0); exp_pix("t1p5", 4, 4, 1);
    cyc(0, 0, 0); exp_st("t1done", 1, 1);
    cyc(0, 0, 0); exp_st("t1idle", 0, 0);

    // Same rectangle with swap on completion
    cyc(1, CMD, 32'h3);
    cyc(0, 0, 0); exp_pix("t2p0", 2, 3, 1);
    cyc(0, 0, 0); exp_pix("t2p1", 3, 3, 1);
    cyc(0, 0, 0); exp_pix("t2p2", 4, 3, 1);
    cyc(0, 0, 0); exp_pix("t2p3", 2, 4, 1);
    cyc(0, 0, 0); exp_pix("t2p4", 3, 4, 1);
    cyc(0, 0, 0); exp_pix("t2p5", 4, 4, 1);
    cyc(0, 0, 0); exp_swap("t2swap");
    cyc(0, 0, 0); exp_st("t2done", 1, 1);
    cyc(0, 0, 0); exp_st("t2idle", 0, 0);

    // CPU pass-through stalls the engine on two cycles
    cyc(1, CMD, 32'h1);
    cyc(0, 0, 0); exp_pix("t3p0", 2, 3, 1);
    cyc(1, 24'h000005, 32'h000000a5); exp_cpu("t3cpu0", 24'h5, 32'ha5);
    cyc(0, 0, 0); exp_pix("t3p1", 3, 3, 1);
    cyc(0, 0, 0); exp_pix("t3p2", 4, 3, 1);
    cyc(1, 24'h000005, 32'h0000005a); exp_cpu("t3cpu1", 24'h5, 32'h5a);
    cyc(0, 0, 0); exp_pix("t3p3", 2, 4, 1);
    cyc(0, 0, 0); exp_pix("t3p4", 3, 4, 1);
    cyc(0, 0, 0); exp_pix("t3p5", 4, 4, 1);
    cyc(0, 0, 0); exp_st("t3done", 1, 1);
    cyc(0, 0, 0); exp_st("t3idle", 0, 0);

    // Empty rectangle: no pixels, one busy cycle
    cyc(1, R0, xy(10, 0));
    cyc(1, R1, xy(5, 0));
    cyc(1, CMD, 32'h1);
    cyc(0, 0, 0); exp_st("t4done", 1, 1);
    cyc(0, 0, 0); exp_st("t4idle", 0, 0);

    // Empty rectangle still honours swap
    cyc(1, CMD, 32'h3);
    cyc(0, 0, 0); exp_swap("t4swap");
    chk("t4swap.done", 32'(done), 32'd0);
    cyc(0, 0, 0); exp_st("t4sdone", 1, 1);
    cyc(0, 0, 0); exp_st("t4sidle", 0, 0);

    // Clamping at the bottom-right corner, colour 0
    cyc(1, R0, xy(638, 478));
    cyc(1, R1, xy(1000, 1000));
    cyc(1, CMD, 32'h0);
    cyc(0, 0, 0); exp_pix("t5p0", 638, 478, 0);
    cyc(0, 0, 0); exp_pix("t5p1", 639, 478, 0);
    cyc(0, 0, 0); exp_pix("t5p2", 638, 479, 0);
    cyc(0, 0, 0); exp_pix("t5p3", 639, 479, 0);
    cyc(0, 0, 0); exp_st("t5done", 1, 1);
    cyc(0, 0, 0); exp_st("t5idle", 0, 0);

    // RECT0 rewrite and CMD while busy do not disturb the fill
    cyc(1, R0, xy(2, 3));
    cyc(1, R1, xy(4, 4));
    cyc(1, CMD, 32'h1);
    cyc(1, R0, xy(0, 0)); exp_pix("t6p0", 2, 3, 1);
    cyc(1, CMD, 32'h3); exp_pix("t6p1", 3, 3, 1);
    cyc(0, 0, 0); exp_pix("t6p2", 4, 3, 1);
    cyc(0, 0, 0); exp_pix("t6p3", 2, 4, 1);
    cyc(0, 0, 0); exp_pix("t6p4", 3, 4, 1);
    cyc(0, 0, 0); exp_pix("t6p5", 4, 4, 1);
    cyc(0, 0, 0); exp_st("t6done", 1, 1);
    cyc(0, 0, 0); exp_st("t6idle0", 0, 0);
    cyc(0, 0, 0); exp_st("t6idle1", 0, 0);

    // Reset after the second pixel aborts the operation
    cyc(1, R0, xy(2, 3));
    cyc(1, CMD, 32'h1);
    cyc(0, 0, 0); exp_pix("t7p0", 2, 3, 1);
    cyc(0, 0, 0); exp_pix("t7p1", 3, 3, 1);
    reset = 1'b1;
    cyc(0, 0, 0); exp_st("t7rst", 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0); exp_st("t7post0", 0, 0);
    cyc(0, 0, 0); exp_st("t7post1", 0, 0);
    cyc(0, 0, 0); exp_st("t7post2", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fill_engine.md
Name: vga_fill_engine

Overview:
- Hardware rectangle-fill engine on the CPU→framebuffer write path, directly upstream of the VGA framebuffer/double-buffer I/O block.
- CPU programs corner coordinates and a colour, then issues a command. The engine streams one pixel write per free cycle into the framebuffer's write port and can optionally toggle the display buffer when finished.
- Ordinary CPU writes pass through to the framebuffer with priority over engine writes.

Parameters:
- WIDTH, 640, horizontal pixel count; x coordinates ≥ WIDTH are clamped or rejected (see Behaviour).
- HEIGHT, 480, vertical pixel count; same rule for y.

Ports:
- clk  in  1  system clock; same clock as the framebuffer write side.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  24  CPU I/O word address.
- cpu_datain  in  32  CPU write data.
- cpu_we  in  1  CPU write strobe, one cycle per write.
- fb_addr  out  24  to framebuffer addr; pixel address = {4'h0, y[9:0], x[9:0]}; 24'hfffffc = buffer swap.
- fb_datain  out  32  to framebuffer datain; nonzero = lit pixel.
- fb_we  out  1  to framebuffer we.
- busy  out  1  high from the cycle after CMD is accepted until DONE exits.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Register map (CPU writes only; never forwarded to fb):
  - 24'hfffff0 RECT0: x0 = datain[9:0], y0 = datain[25:16].
  - 24'hfffff4 RECT1: x1 = datain[9:0], y1 = datain[25:16].
  - 24'hfffff8 CMD: bit0 = colour, bit1 = swap_on_done; the write starts an operation.
- RECT registers are writable at any time. CMD latches working copies of x0, y0, x1, y1, colour and swap; later RECT writes do not affect the running operation.
- CMD written while busy is ignored.
- Bus mux, combinational:
  - If cpu_we and cpu_addr is not an engine register: fb_* = cpu_*; the engine stalls this cycle with no counter advance.
  - Otherwise fb_* = engine outputs; fb_we = 0 when the engine is not issuing a write.
- Clipping at CMD: x1 clamps to WIDTH-1 and y1 to HEIGHT-1. The operation is empty if x0 > x1, y0 > y1, x0 ≥ WIDTH or y0 ≥ HEIGHT.
- FSM states: IDLE, FILL, SWAP, DONE.
  - IDLE: on a CMD write at cycle N → FILL at N+1 with x = x0, y = y0. An empty op goes to DONE at N+1 instead, issuing no pixel writes but still honouring swap_on_done via SWAP.
  - FILL: each non-stalled cycle, fb_we = 1, fb_addr = {4'h0, y, x}, fb_datain = {31'b0, colour}.
    - x advances when x ≠ x1.
    - At x == x1: x ← x0, y ← y+1.
    - At (x1, y1), after the write: → SWAP if swap set, else DONE.
    - Row-major order; exactly (x1−x0+1)·(y1−y0+1) writes. Unstalled latency = that many cycles.
  - SWAP: on the first non-stalled cycle, fb_we = 1, fb_addr = 24'hfffffc, fb_datain = 0; then → DONE.
  - DONE: done = 1 for one cycle; busy = 1 during this cycle; → IDLE.
- CPU write to 24'hfffffc while busy: forwarded as a normal CPU write, which toggles the buffer. Software must avoid this.
- Reset values: state IDLE, busy 0, done 0, fb_we 0 unless passing a CPU write through, all coordinate registers 0, colour 0, swap 0.
- Reset mid-operation aborts the operation; no engine writes from the next cycle on.
- Counters are 10-bit; because of clamping, y never increments past y1.

Test Plan:
- RECT0 = (2,3), RECT1 = (4,4), CMD = 0x1 → 6 consecutive writes to {y,x} = (3,2), (3,3), (3,4), (4,2), (4,3), (4,4) with datain 1, starting the cycle after CMD; done pulses the cycle after the last write; busy high for 7 cycles.
- Same rectangle, CMD = 0x3 → 6 pixel writes, then one write to 24'hfffffc with data 0, then done.
- During FILL, CPU writes addr 0x000005 on two separate cycles → both forwarded unchanged; engine address sequence is unchanged, finishing 2 cycles later; total engine writes still 6.
- RECT0 = (10,0), RECT1 = (5,0), CMD → zero pixel writes; busy for 1 cycle; done pulse. RECT1 = (1000,1000) with RECT0 = (638,478) → 4 writes, clamped to x ≤ 639, y ≤ 479.
- CMD issued while busy, and RECT0 rewritten mid-fill → the running fill is unaffected and no second operation starts. Assert reset after the 2nd pixel → fb_we = 0 next cycle, busy = 0, done never pulses.
